id_stream_driver: RTL and testbench

- Producer side of the graph ID interface: buffers incoming message IDs from the host, paces them onto ID_out/data_rdy at a rate the graph block can absorb, and counts WINSIZE issues per window.
- After each window, captures the graph's num_edges on data_vld and returns it to the host over a valid/ready result port.
- Sits between the host/testbench stream source and graph.

---
 rtl/graph_pkg.sv | 22 ++
 rtl/id_fifo.sv | 80 ++++++++
 rtl/id_stream_driver.sv | 206 ++++++++++++++++++++
 tb/tb_id_stream_driver.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// Shared types and defaults for the graph ID interface.
// Contents: default widths, driver state enum, id_t, ERR_EDGES marker.
package graph_pkg;

  localparam int unsigned DEF_WINSIZE    = 200;
  localparam int unsigned DEF_ID_WIDTH   = 11;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_WAIT_RES,
    ST_HOLD_RES
  } drv_state_e;

  typedef logic [DEF_ID_WIDTH-1:0] id_t;

  // Wide all-ones marker; users truncate to their edge-count width.
  localparam logic [31:0] ERR_EDGES = '1;

endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO for host IDs with a registered head word.
// Ports: clk, rst (async, active-high), push/push_data, pop,
//        head (oldest entry), not_full, empty, empty_nxt_c (next-cycle empty).
module id_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_full,
  output logic             empty,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push && not_full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  // Occupancy tracking.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  assign empty_nxt_c = (count_nxt == '0);

  // Pointers, flags and head register; head forwards push_data when the
  // word being written becomes the new head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
      head     <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      not_full <= (count_nxt != CW'(DEPTH));
      empty    <= empty_nxt_c;
      if (do_push && (wr_ptr == rd_ptr_nxt)) begin
        head <= push_data;
      end else begin
        head <= mem[rd_ptr_nxt];
      end
    end
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/id_stream_driver.sv
// Paces buffered host IDs onto ID_out/data_rdy, counts WINSIZE issues per
// window, then returns the graph's num_edges over a valid/ready result port.
// Ports: clk, rst (async, active-high); s_id_valid/s_id_ready/s_id_data host
//        input; data_rdy/ID_out to graph; data_vld/num_edges from graph;
//        m_res_valid/m_res_ready/m_res_edges/m_res_win_idx result; busy;
//        err_unexp (sticky); err_timeout (sticky, only with macro).
// Optional macro ID_STREAM_TIMEOUT_EN adds a WAIT_RES watchdog.
module id_stream_driver
  import graph_pkg::*;
#(
  parameter int unsigned WINSIZE        = DEF_WINSIZE,
  parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned GAP_CYCLES     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_id_valid,
  output logic                  s_id_ready,
  input  logic [ID_WIDTH-1:0]   s_id_data,
  output logic                  data_rdy,
  output logic [ID_WIDTH-1:0]   ID_out,
  input  logic                  data_vld,
  input  logic [DATA_WIDTH-1:0] num_edges,
  output logic                  m_res_valid,
  input  logic                  m_res_ready,
  output logic [DATA_WIDTH-1:0] m_res_edges,
  output logic [15:0]           m_res_win_idx,
  output logic                  busy,
  output logic                  err_unexp
`ifdef ID_STREAM_TIMEOUT_EN
  ,
  output logic                  err_timeout
`endif
);

  localparam int unsigned CNT_W = $clog2(WINSIZE) + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;

  drv_state_e            state;
  drv_state_e            state_nxt;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      issue_cnt_d;
  logic [GAP_W-1:0]      gap_cnt;
  logic [GAP_W-1:0]      gap_cnt_d;
  logic                  data_rdy_d;
  logic [ID_WIDTH-1:0]   id_out_d;
  logic                  res_valid_d;
  logic [DATA_WIDTH-1:0] res_edges_d;
  logic [15:0]           win_idx_d;
  logic                  busy_d;
  logic                  err_unexp_d;
  logic                  fifo_pop;
  logic [ID_WIDTH-1:0]   fifo_head;
  logic                  fifo_empty;
  logic                  fifo_empty_nxt;
  logic                  res_accept;
  logic                  timeout_hit;

`ifdef ID_STREAM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] wd_cnt;
  logic [TO_W-1:0] wd_cnt_d;
  logic            err_timeout_d;
  assign timeout_hit = (state == ST_WAIT_RES) && !data_vld &&
                       (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign res_accept = (state == ST_HOLD_RES) && m_res_valid && m_res_ready;

  id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (s_id_valid),
    .push_data   (s_id_data),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .not_full    (s_id_ready),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && (gap_cnt == '0)) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_GAP;
      ST_GAP: begin
        if (gap_cnt == '0) begin
          if (issue_cnt == CNT_W'(WINSIZE)) state_nxt = ST_WAIT_RES;
          else if (!fifo_empty)             state_nxt = ST_ISSUE;
          else                              state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_RES: begin
        if (data_vld || timeout_hit) state_nxt = ST_HOLD_RES;
      end
      ST_HOLD_RES: begin
        if (res_accept) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values. Issue actions are registered on the edge
  // entering ISSUE so data_rdy, ID_out and the gap load line up with it.
  always_comb begin
    fifo_pop    = 1'b0;
    data_rdy_d  = 1'b0;
    id_out_d    = ID_out;
    issue_cnt_d = issue_cnt;
    gap_cnt_d   = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : gap_cnt;
    res_valid_d = m_res_valid;
    res_edges_d = m_res_edges;
    win_idx_d   = m_res_win_idx;
    err_unexp_d = err_unexp | (data_vld && (state != ST_WAIT_RES));
`ifdef ID_STREAM_TIMEOUT_EN
    wd_cnt_d      = (state == ST_WAIT_RES) ? wd_cnt + TO_W'(1) : '0;
    err_timeout_d = err_timeout | timeout_hit;
`endif

    if (state_nxt == ST_ISSUE) begin
      fifo_pop    = 1'b1;
      data_rdy_d  = 1'b1;
      id_out_d    = fifo_head;
      issue_cnt_d = issue_cnt + CNT_W'(1);
      gap_cnt_d   = GAP_W'(GAP_CYCLES - 1);
    end

    if ((state == ST_WAIT_RES) && data_vld) begin
      res_valid_d = 1'b1;
      res_edges_d = num_edges;
      issue_cnt_d = '0;
    end else if (timeout_hit) begin
      res_valid_d = 1'b1;
      res_edges_d = DATA_WIDTH'(ERR_EDGES);
      issue_cnt_d = '0;
    end

    if (res_accept) begin
      res_valid_d = 1'b0;
      win_idx_d   = m_res_win_idx + 16'd1;
      gap_cnt_d   = GAP_W'(GAP_CYCLES - 1);
    end

    busy_d = !((state_nxt == ST_IDLE) && fifo_empty_nxt);
  end

  // Registered outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rdy      <= 1'b0;
      ID_out        <= '0;
      issue_cnt     <= '0;
      gap_cnt       <= '0;
      m_res_valid   <= 1'b0;
      m_res_edges   <= '0;
      m_res_win_idx <= '0;
      busy          <= 1'b0;
      err_unexp     <= 1'b0;
    end else begin
      data_rdy      <= data_rdy_d;
      ID_out        <= id_out_d;
      issue_cnt     <= issue_cnt_d;
      gap_cnt       <= gap_cnt_d;
      m_res_valid   <= res_valid_d;
      m_res_edges   <= res_edges_d;
      m_res_win_idx <= win_idx_d;
      busy          <= busy_d;
      err_unexp     <= err_unexp_d;
    end
  end

`ifdef ID_STREAM_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= wd_cnt_d;
      err_timeout <= err_timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_id_stream_driver.sv
// Scoreboard bench for id_stream_driver (WINSIZE=4, GAP_CYCLES=6).
module tb_id_stream_driver;

  localparam int unsigned WIN = 4;
  localparam int unsigned GAP = 6;
  localparam int unsigned IDW = 11;
  localparam int unsigned DW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_id_valid;
  logic           s_id_ready;
  logic [IDW-1:0] s_id_data;
  logic           data_rdy;
  logic [IDW-1:0] ID_out;
  logic           data_vld;
  logic [DW-1:0]  num_edges;
  logic           m_res_valid;
  logic           m_res_ready;
  logic [DW-1:0]  m_res_edges;
  logic [15:0]    m_res_win_idx;
  logic           busy;
  logic           err_unexp;
`ifdef ID_STREAM_TIMEOUT_EN
  logic           err_timeout;
`endif

  id_stream_driver #(
    .WINSIZE    (WIN),
    .ID_WIDTH   (IDW),
    .DATA_WIDTH (DW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_id_valid    (s_id_valid),
    .s_id_ready    (s_id_ready),
    .s_id_data     (s_id_data),
    .data_rdy      (data_rdy),
    .ID_out        (ID_out),
    .data_vld      (data_vld),
    .num_edges     (num_edges),
    .m_res_valid   (m_res_valid),
    .m_res_ready   (m_res_ready),
    .m_res_edges   (m_res_edges),
    .m_res_win_idx (m_res_win_idx),
    .busy          (busy),
    .err_unexp     (err_unexp)
`ifdef ID_STREAM_TIMEOUT_EN
    ,
    .err_timeout   (err_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [IDW-1:0] exp_id[$];
  logic [23:0]    exp_res[$];   // {edges, win_idx}
  int             pulse_times[$];
  int             pulse_cnt = 0;
  int             accept_cnt = 0;
  int             valid_cycles = 0;
  int             last_hs_cyc = 0;
  logic [15:0]    exp_idx = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s actual=%0d required>=%0d", name, act, min);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT issues or hands over a result.
  initial begin
    int          last_pulse_cyc = 0;
    int          last_accept_cyc = 0;
    bit          have_pulse = 0;
    bit          accept_pending = 0;
    bit          have_id = 0;
    logic [IDW-1:0] last_id = '0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_pulse     = 0;
        accept_pending = 0;
        have_id        = 0;
      end else begin
        if (data_rdy) begin
          pulse_cnt++;
          pulse_times.push_back(cyc);
          if (exp_id.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexp_issue actual=%0h required=none", ID_out);
          end else begin
            chk("issue_id", 32'(ID_out), 32'(exp_id.pop_front()));
          end
          if (have_pulse) chk_ge("pulse_spacing", cyc - last_pulse_cyc, GAP);
          if (accept_pending) chk_ge("issue_after_accept", cyc - last_accept_cyc, GAP);
          have_pulse     = 1;
          accept_pending = 0;
          last_pulse_cyc = cyc;
          last_id        = ID_out;
          have_id        = 1;
        end else if (have_id) begin
          chk("id_hold", 32'(ID_out), 32'(last_id));
        end
        if (m_res_valid) begin
          valid_cycles++;
          if (m_res_ready) begin
            accept_cnt++;
            last_accept_cyc = cyc;
            accept_pending  = 1;
            if (exp_res.size() == 0) begin
              errors++; checks++;
              $display("FAIL unexp_result actual=%0h required=none", m_res_edges);
            end else begin
              e = exp_res.pop_front();
              chk("res_edges", 32'(m_res_edges), 32'(e[23:16]));
              chk("res_win_idx", 32'(m_res_win_idx), 32'(e[15:0]));
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_id(input logic [IDW-1:0] id);
    bit hs = 0;
    int n = 0;
    s_id_valid = 1'b1;
    s_id_data  = id;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = s_id_ready;
      if (hs) last_hs_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    s_id_valid = 1'b0;
    if (hs) exp_id.push_back(id);
    else    fail("push_handshake");
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pulse_cnt < target) fail("wait_pulses");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n = 0;
    while (accept_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (accept_cnt < target) fail("wait_accepts");
    @(posedge clk);
    #1;
  endtask

  task automatic send_result(input logic [DW-1:0] edges);
    data_vld  = 1'b1;
    num_edges = edges;
    exp_res.push_back({edges, exp_idx});
    exp_idx++;
    tick(1);
    data_vld  = 1'b0;
  endtask

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int v0;
    int pc;
    rst = 1'b1; s_id_valid = 1'b0; s_id_data = '0;
    data_vld = 1'b0; num_edges = '0; m_res_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_data_rdy", 32'(data_rdy), 0);
    chk("rst_id_out", 32'(ID_out), 0);
    chk("rst_res_valid", 32'(m_res_valid), 0);
    chk("rst_res_edges", 32'(m_res_edges), 0);
    chk("rst_win_idx", 32'(m_res_win_idx), 0);
    chk("rst_err_unexp", 32'(err_unexp), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    // Window 0: four back-to-back IDs, exact 6-cycle pacing.
    push_id(11'h010); push_id(11'h020); push_id(11'h030); push_id(11'h040);
    wait_pulses(4, 200);
    chk("pace_0_1", 32'(pulse_times[1] - pulse_times[0]), 6);
    chk("pace_1_2", 32'(pulse_times[2] - pulse_times[1]), 6);
    chk("pace_2_3", 32'(pulse_times[3] - pulse_times[2]), 6);
    tick(8);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_no_res", 32'(m_res_valid), 0);

    // Result with immediate acceptance.
    v0 = valid_cycles;
    send_result(8'd3);
    wait_accepts(1, 20);
    tick(2);
    chk("res_valid_one_cycle", 32'(valid_cycles - v0), 1);
    chk("win_idx_after", 32'(m_res_win_idx), 1);

    // Window 1: result held 20 cycles while 4 more IDs queue.
    push_id(11'h051); push_id(11'h052); push_id(11'h053); push_id(11'h054);
    wait_pulses(8, 200);
    tick(8);
    m_res_ready = 1'b0;
    send_result(8'd5);
    pc = pulse_cnt;
    push_id(11'h061); push_id(11'h062); push_id(11'h063); push_id(11'h064);
    tick(16);
    chk("hold_no_issue", 32'(pulse_cnt), 32'(pc));
    chk("hold_res_valid", 32'(m_res_valid), 1);
    chk("hold_edges", 32'(m_res_edges), 5);
    m_res_ready = 1'b1;
    wait_accepts(2, 20);
    wait_pulses(12, 200);
    tick(8);

    // Window 2 result stalled; fill the FIFO with 17 IDs.
    m_res_ready = 1'b0;
    send_result(8'd7);
    for (int i = 0; i < 16; i++) push_id(11'(11'h100 + i));
    @(negedge clk);
    chk("full_ready_low", 32'(s_id_ready), 0);
    @(posedge clk); #1;
    fork
      push_id(11'h110);
      begin
        tick(3);
        m_res_ready = 1'b1;
      end
    join
    if (pulse_times.size() > 12) chk_ge("push17_after_pop", last_hs_cyc - pulse_times[12], 0);
    else fail("push17_pulse");
    for (int w = 0; w < 4; w++) begin
      wait_pulses(16 + 4 * w, 300);
      tick(8);
      send_result(8'(8'h10 + w));
    end
    wait_pulses(29, 300);
    tick(10);

    // Unexpected data_vld in IDLE.
    data_vld = 1'b1; num_edges = 8'h77;
    tick(1);
    data_vld = 1'b0;
    tick(1);
    chk("err_unexp_set", 32'(err_unexp), 1);
    tick(10);
    chk("err_unexp_sticky", 32'(err_unexp), 1);
    chk("unexp_no_res", 32'(m_res_valid), 0);
    push_id(11'h201); push_id(11'h202); push_id(11'h203);
    wait_pulses(32, 200);
    tick(8);
    send_result(8'h2A);
    wait_accepts(8, 20);

    // Reset mid-window after 2 of 4 issues.
    push_id(11'h301); push_id(11'h302); push_id(11'h303); push_id(11'h304);
    wait_pulses(34, 200);
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data_rdy", 32'(data_rdy), 0);
    chk("mid_rst_id_out", 32'(ID_out), 0);
    chk("mid_rst_res_valid", 32'(m_res_valid), 0);
    chk("mid_rst_win_idx", 32'(m_res_win_idx), 0);
    chk("mid_rst_err_unexp", 32'(err_unexp), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    exp_id.delete();
    exp_idx = 16'd0;
    tick(2);
    rst = 1'b0;
    tick(2);
    push_id(11'h401); push_id(11'h402); push_id(11'h403); push_id(11'h404);
    wait_pulses(38, 200);
    tick(8);
    send_result(8'd9);
    wait_accepts(9, 20);
    chk("post_rst_win_idx", 32'(m_res_win_idx), 1);

`ifdef ID_STREAM_TIMEOUT_EN
    // Window with no graph response: watchdog result.
    push_id(11'h501); push_id(11'h502); push_id(11'h503); push_id(11'h504);
    wait_pulses(42, 200);
    exp_res.push_back({8'hFF, exp_idx});
    exp_idx++;
    wait_accepts(10, 1200);
    chk("err_timeout", 32'(err_timeout), 1);
`endif

    tick(10);
    chk("end_busy", 32'(busy), 0);
    chk("end_exp_id_empty", 32'(exp_id.size()), 0);
    chk("end_exp_res_empty", 32'(exp_res.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
